// File: rtl/sig_gen.sv
// Square-wave DDS source: a phase accumulator whose MSB is the output, run continuously or for N periods.
// New tuning words are switched in only on a period boundary, so sig_out never glitches.
module sig_gen #(
  parameter int ACC_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic               en,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [ACC_W-1:0]   tw_in,
  input  logic               tw_valid,
  output logic               tw_ready,
  output logic               sig_out,
  output logic               period_strb,
  output logic [31:0]        period_cnt,
  output logic               active,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ACC_W-1:0]   TW_MAX = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [BURST_W-1:0] ONE_B  = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t             state, state_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic [ACC_W-1:0]   tw_act, tw_act_d;
  logic [ACC_W-1:0]   tw_pend, tw_pend_d;
  logic               pend, pend_d;
  logic               strb_d, done_d;
  logic [31:0]        cnt_d;
  logic [BURST_W-1:0] remaining, remaining_d;
  logic [BURST_W-1:0] burst_len_s, burst_len_s_d;
  logic [ACC_W:0]     sum;
  logic               running, carry, take;

  // Tuning-word handshake: a word transfers on any cycle where tw_valid && tw_ready are both high;
  // tw_ready is low exactly while an accepted word waits in tw_pend for its switch-over point.
  always_comb begin
    sum           = {1'b0, acc} + {1'b0, tw_act};
    running       = (state == RUN) || (state == STOP);
    carry         = running && sum[ACC_W];
    state_d       = state;
    acc_d         = acc;
    tw_act_d      = tw_act;
    tw_pend_d     = tw_pend;
    pend_d        = pend;
    cnt_d         = period_cnt;
    remaining_d   = remaining;
    burst_len_s_d = burst_len_s;
    strb_d        = 1'b0;
    done_d        = 1'b0;
    take          = 1'b0;

    // A stalled accumulator (tw_act==0) has no boundary to wait for, so it switches at once.
    if (pend) begin
      take = (state == IDLE) || (state == DONE) ||
             ((state == RUN) && (tw_act == '0)) || carry;
    end
    if (take) begin
      tw_act_d = tw_pend;
      pend_d   = 1'b0;
    end else if (tw_valid && !pend) begin
      tw_pend_d = (tw_in >= TW_MAX) ? TW_MAX : tw_in;
      pend_d    = 1'b1;
    end

    if (carry) begin
      strb_d = 1'b1;
      cnt_d  = period_cnt + 32'd1;
      if (burst_len_s != '0) remaining_d = remaining - ONE_B;
    end

    case (state)
      IDLE: begin
        acc_d = '0;
        if (en) begin
          state_d       = RUN;
          remaining_d   = burst_len;
          burst_len_s_d = burst_len;
          cnt_d         = '0;
        end
      end
      RUN: begin
        acc_d = sum[ACC_W-1:0];
        if (carry && (burst_len_s != '0) && (remaining == ONE_B)) begin
          state_d = DONE;
          done_d  = 1'b1;
          acc_d   = '0;
        end else if (!en) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Finish the current period so the last high phase is never truncated.
        acc_d = sum[ACC_W-1:0];
        if (carry || (tw_act == '0)) begin
          state_d = IDLE;
          acc_d   = '0;
        end
      end
      DONE: begin
        acc_d = '0;
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      tw_act      <= '0;
      tw_pend     <= '0;
      pend        <= 1'b0;
      period_strb <= 1'b0;
      period_cnt  <= '0;
      done        <= 1'b0;
      remaining   <= '0;
      burst_len_s <= '0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      tw_act      <= tw_act_d;
      tw_pend     <= tw_pend_d;
      pend        <= pend_d;
      period_strb <= strb_d;
      period_cnt  <= cnt_d;
      done        <= done_d;
      remaining   <= remaining_d;
      burst_len_s <= burst_len_s_d;
    end
  end

  assign sig_out   = acc[ACC_W-1];
  assign tw_ready  = ~pend;
  assign active    = (state == RUN) || (state == STOP);
  assign state_dbg = state;

endmodule
